// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: imem request/response, decode handoff and branch feedback.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        br_taken;
    logic [31:0] br_imm;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, misalign_err,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_imm
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, misalign_err,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_imm
    );
endinterface

// File: rtl/instr_fetch.sv
// RV32 fetch stage: single-outstanding imem requests, holds {instr, pc} for decode,
// applies taken-branch redirects and halts on a misaligned target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic        r_err;
    logic [31:0] w_target;

    assign w_target = r_if_pc + bus.br_imm;

    assign bus.imem_req     = r_req;
    assign bus.imem_addr    = r_pc;
    assign bus.if_valid     = r_valid;
    assign bus.if_instr     = r_instr;
    assign bus.if_pc        = r_if_pc;
    assign bus.misalign_err = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_if_pc <= RESET_PC;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // req is low for the first cycle after reset release, so gnt only counts once req is up
                    if (r_req && bus.imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_instr <= bus.imem_rdata;
                        r_if_pc <= r_pc;
                        r_pc    <= r_pc + 32'd4;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bus.if_ready) begin
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (bus.br_taken && (w_target[1:0] != 2'b00)) begin
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            if (bus.br_taken) r_pc <= w_target;
                            r_req   <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
